// File: rtl/order_reporter.sv
// order_reporter: return path from the arbitrage logic to the HPS.
// Debounces the exchange action tuple, turns each newly settled valid trade
// into a 32-bit order record, queues records in a small FIFO and presents
// them one at a time over a four-phase valid/ack handshake.
module order_reporter #(
  parameter int unsigned DEPTH  = 8,
  parameter int unsigned SETTLE = 4,
  parameter logic [1:0]  HOLD_C = 2'b00,
  parameter logic [1:0]  BUY_C  = 2'b01,
  parameter logic [1:0]  SELL_C = 2'b10
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [15:0]              price_a,
  input  logic [15:0]              price_b,
  input  logic [15:0]              price_c,
  input  logic [1:0]               action_a,
  input  logic [1:0]               action_b,
  input  logic [1:0]               action_c,
  input  logic                     order_ack,
  output logic                     order_valid,
  output logic [31:0]              order_data,
  output logic [$clog2(DEPTH):0]   fifo_count,
  output logic [7:0]               drop_count,
  output logic                     overflow
);

  localparam int unsigned AW   = $clog2(DEPTH);
  localparam int unsigned CNTW = AW + 1;
  localparam int unsigned SW   = $clog2(SETTLE + 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PRESENT = 2'd1,
    RELEASE = 2'd2
  } state_t;

  // Settle filter state
  logic [5:0]    tuple;
  logic [5:0]    act_q;
  logic [5:0]    last_tuple;
  logic [SW-1:0] stable_cnt;
  logic          settle_evt;

  // Trade decode
  logic          trade_ok;
  logic [1:0]    buy_ex;
  logic [1:0]    sell_ex;
  logic [15:0]   buy_price;
  logic [15:0]   sell_price;
  logic [15:0]   spread;
  logic [31:0]   record;
  logic [7:0]    seq;

  // FIFO
  logic [31:0]   mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          full;
  logic          push_req;
  logic          push_ok;
  logic          pop;
  logic          drop;

  // Handshake FSM
  state_t        state;
  state_t        state_n;
  logic          load_data;

  assign tuple = {action_a, action_b, action_c};

  // The settle event is the cycle in which stable_cnt steps from SETTLE-1 to SETTLE.
  assign settle_evt = (tuple == act_q) && (stable_cnt == SW'(SETTLE - 1));

  // Register the tuple and count how long it has been unchanged.
  always_ff @(posedge clk) begin
    if (reset) begin
      act_q      <= '1;
      last_tuple <= '1;
      stable_cnt <= '0;
    end else begin
      act_q <= tuple;
      if (tuple != act_q) begin
        stable_cnt <= '0;
      end else if (stable_cnt != SW'(SETTLE)) begin
        stable_cnt <= stable_cnt + SW'(1);
      end
      if (settle_evt) begin
        last_tuple <= tuple;
      end
    end
  end

  // Classify the tuple: exactly one buy, one sell and one hold is a trade.
  always_comb begin
    logic [1:0] n_buy;
    logic [1:0] n_sell;
    logic [1:0] n_hold;
    logic [1:0] f;
    n_buy   = '0;
    n_sell  = '0;
    n_hold  = '0;
    buy_ex  = '0;
    sell_ex = '0;
    f       = '0;
    for (int unsigned i = 0; i < 3; i++) begin
      f = tuple[(5 - 2*i) -: 2];
      if (f == BUY_C) begin
        n_buy  = n_buy + 2'd1;
        buy_ex = 2'(i);
      end else if (f == SELL_C) begin
        n_sell  = n_sell + 2'd1;
        sell_ex = 2'(i);
      end else if (f == HOLD_C) begin
        n_hold = n_hold + 2'd1;
      end
    end
    trade_ok = (n_buy == 2'd1) && (n_sell == 2'd1) && (n_hold == 2'd1);
  end

  // Select the buy-side and sell-side prices by exchange index.
  always_comb begin
    buy_price  = price_c;
    sell_price = price_c;
    case (buy_ex)
      2'd0:    buy_price = price_a;
      2'd1:    buy_price = price_b;
      default: buy_price = price_c;
    endcase
    case (sell_ex)
      2'd0:    sell_price = price_a;
      2'd1:    sell_price = price_b;
      default: sell_price = price_c;
    endcase
  end

  assign spread = sell_price - buy_price;
  assign record = {seq, 2'b00, buy_ex, sell_ex, 2'b00, spread};

  assign push_req = settle_evt && trade_ok && (tuple != last_tuple);
  assign pop      = (state == PRESENT) && order_ack;
  assign full     = (fifo_count == CNTW'(DEPTH));
  // A pop in the same cycle frees the head slot, so a full FIFO can still accept.
  assign push_ok  = push_req && (!full || pop);
  assign drop     = push_req && full && !pop;

  // Record storage; contents need no reset since pointers define validity.
  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem[wr_ptr] <= record;
    end
  end

  // FIFO pointers and occupancy.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
    end else begin
      if (push_ok) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      case ({push_ok, pop})
        2'b10:   fifo_count <= fifo_count + CNTW'(1);
        2'b01:   fifo_count <= fifo_count - CNTW'(1);
        default: fifo_count <= fifo_count;
      endcase
    end
  end

  // Sequence numbering and loss accounting; seq advances even for dropped records.
  always_ff @(posedge clk) begin
    if (reset) begin
      seq        <= '0;
      drop_count <= '0;
      overflow   <= 1'b0;
    end else begin
      if (push_req) begin
        seq <= seq + 8'd1;
      end
      if (drop) begin
        overflow <= 1'b1;
        if (drop_count != 8'hFF) begin
          drop_count <= drop_count + 8'd1;
        end
      end
    end
  end

  // Handshake state register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_n;
    end
  end

  // Handshake next-state and outputs; a stale high ack holds the FSM in IDLE.
  always_comb begin
    state_n     = state;
    order_valid = 1'b0;
    load_data   = 1'b0;
    case (state)
      IDLE: begin
        if ((fifo_count != '0) && !order_ack) begin
          state_n   = PRESENT;
          load_data = 1'b1;
        end
      end
      PRESENT: begin
        order_valid = 1'b1;
        if (order_ack) begin
          state_n = RELEASE;
        end
      end
      RELEASE: begin
        if (!order_ack) begin
          state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // Capture the FIFO head only when a record is about to be presented.
  always_ff @(posedge clk) begin
    if (reset) begin
      order_data <= '0;
    end else if (load_data) begin
      order_data <= mem[rd_ptr];
    end
  end

endmodule
